axioma_ext_int: RTL and testbench
=================================

# axioma_ext_int

External and pin-change interrupt front end for AxiomaCore-328. It synchronizes the INT0/INT1 and PCINT0–23 port pins and applies EICRA sense control and PCMSKn masks. It maintains the EIFR/PCIFR flags and hosts the EICRA, EIMSK, EIFR, PCICR, PCIFR and PCMSK0–2 data-space registers. It sits directly upstream of the interrupt controller: it drives that block's INT0/INT1/PCINT0–2 request inputs and its mask/flag register inputs, and it clears flags when the CPU takes the corresponding vector.

## Interface
- SYNC_STAGES, 2: pin synchronizer depth (≥2).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- int_pins  in  2  raw INT1:INT0 pins (PD3:PD2).
- pcint_pins  in  24  raw PCINT23:0 pins. PCINT15 is ignored.
- io_addr  in  8  data-space address.
- io_wdata  in  8  write data.
- io_we  in  1  write strobe, one cycle per write.
- io_re  in  1  read strobe.
- io_rdata  out  8  read data. Combinational: register value when io_re is high and io_addr hits, else 0x00.
- io_hit  out  1  io_addr matches one of the 8 registers.
- vec_ack  in  1  CPU vector-fetch strobe.
- vec_num  in  6  vector number taken, valid with vec_ack.
- int_req  out  2  INT1:INT0 requests.
- pcint_req  out  3  PCINT2:0 group requests.
- eimsk_reg, eifr_reg, pcicr_reg, pcifr_reg, pcmsk0_reg, pcmsk1_reg, pcmsk2_reg  out  8 each  live register values.

## Operation
- Register map:
  - 0x3C: EIFR, bits 1:0.
  - 0x3D: EIMSK, bits 1:0.
  - 0x3B: PCIFR, bits 2:0.
  - 0x68: PCICR, bits 2:0.
  - 0x69: EICRA, bits 3:0.
  - 0x6B: PCMSK0.
  - 0x6C: PCMSK1. Bit 7 is hardwired 0.
  - 0x6D: PCMSK2.
  - Unimplemented bits read 0 and ignore writes.
- EIFR/PCIFR are write-1-to-clear. A write of 0 has no effect.
- Synchronizer: SYNC_STAGES flops per pin, then one "prev" flop. Edge detection compares the last sync stage against prev.
- Arm counter: counts 0..SYNC_STAGES+1 after reset. All edge detection (INT and PCINT) is suppressed until it saturates, so reset values cannot generate flags.
- EICRA ISCn1:0 for INTn:
  - 00: low level. The flag is never set. int_req[n] = ~sync_n & EIMSK[n].
  - 01: any edge sets EIFR[n].
  - 10: falling edge sets EIFR[n].
  - 11: rising edge sets EIFR[n].
  - For edge modes: int_req[n] = EIFR[n] & EIMSK[n].
- Flags set regardless of EIMSK (AVR behaviour).
- PCINT groups:
  - Group 0 = pins 7:0 with PCMSK0.
  - Group 1 = pins 14:8 with PCMSK1[6:0].
  - Group 2 = pins 23:16 with PCMSK2.
  - PCIFR[g] sets when any pin in the group with its PCMSKg bit set toggles.
  - pcint_req[g] = PCIFR[g] & PCICR[g].
- Vector clear: on vec_ack, vec_num 1/2/3/4/5 clears EIFR0/EIFR1/PCIFR0/PCIFR1/PCIFR2. Other vec_num values are ignored. INT in low-level mode has no flag to clear.
- Flag priority per bit, highest first: hardware set, then clear (W1C or vec_ack), then hold. Set wins over a simultaneous clear.
- A write to EICRA or PCMSKn takes effect on the next edge evaluation. Pending flags are not altered.

## Timing
- Reset values:
  - All registers, flags, sync/prev flops and arm counter are 0.
  - int_req = 0. pcint_req = 0. Register outputs are 0x00.
  - io_rdata = 0. io_hit follows io_addr.
- Flag latency: a pin change first sampled at clock edge N gives flag = 1 after edge N+SYNC_STAGES+1 (N+3 at default). int_req/pcint_req follow the flag combinationally in the same cycle.
- Low-level path: int_req asserts SYNC_STAGES edges after sampling, since it has no prev stage.
- Pulses shorter than one clk may be missed. Pulses of ≥1 clk are guaranteed detected.
- Register writes take effect on the edge where io_we is high. Readback shows the new value in the next cycle.
- vec_ack clears the flag at that edge. The request drops in the following cycle unless a new set arrives at the same edge.
- Reset mid-operation clears everything asynchronously and re-arms the counter. There is no flag carry-over.

## Test plan
- Edge mode, rising edge: EICRA=0x03, EIMSK=0x01, int_pins[0] 0→1 at edge N -> EIFR=0x01 and int_req=01 at N+3. vec_ack with vec_num=1 -> EIFR=0x00 and int_req=00 next cycle.
- Level mode, INT1: EICRA=0x00, EIMSK=0x02, hold int_pins[1]=0 -> int_req[1]=1 while low, EIFR stays 0x00. Release pin -> int_req[1]=0 within 2 cycles.
- PCINT group 2: PCMSK2=0x10, PCICR=0x04, toggle pcint_pins[20] -> PCIFR=0x04, pcint_req=100. Toggle pcint_pins[21] with PCIFR already cleared -> no flag.
- W1C collision: same-cycle write 0x01 to 0x3C and INT0 edge detection -> EIFR[0] remains 1. Write 0x01 next cycle -> EIFR=0x00.
- Reset/arm: pins held at 0xFFFFFF/0x3 through reset release -> no flags ever set. Read 0x6C after writing 0xFF -> 0x7F.
- Reset mid-flag: EIFR=0x03 and reset_n pulsed -> all outputs 0 immediately, with no spurious flags after release.

Source files
------------

// File: rtl/axioma_ext_int.sv
// INT0/INT1 and PCINT0-23 front end: pin sync, sense control, EIFR/PCIFR flags, io registers.
// Flags set SYNC_STAGES+1 edges after a pin is captured; no backpressure, reads are combinational.
module axioma_ext_int #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] int_pins,
    input  logic [23:0] pcint_pins,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    input  logic       io_we,
    input  logic       io_re,
    output logic [7:0] io_rdata,
    output logic       io_hit,
    input  logic       vec_ack,
    input  logic [5:0] vec_num,
    output logic [1:0] int_req,
    output logic [2:0] pcint_req,
    output logic [7:0] eimsk_reg,
    output logic [7:0] eifr_reg,
    output logic [7:0] pcicr_reg,
    output logic [7:0] pcifr_reg,
    output logic [7:0] pcmsk0_reg,
    output logic [7:0] pcmsk1_reg,
    output logic [7:0] pcmsk2_reg
);
    localparam logic [7:0] ADDR_PCIFR  = 8'h3B;
    localparam logic [7:0] ADDR_EIFR   = 8'h3C;
    localparam logic [7:0] ADDR_EIMSK  = 8'h3D;
    localparam logic [7:0] ADDR_PCICR  = 8'h68;
    localparam logic [7:0] ADDR_EICRA  = 8'h69;
    localparam logic [7:0] ADDR_PCMSK0 = 8'h6B;
    localparam logic [7:0] ADDR_PCMSK1 = 8'h6C;
    localparam logic [7:0] ADDR_PCMSK2 = 8'h6D;
    localparam int NPIN    = 26;
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0][NPIN-1:0] sync_q, sync_d;
    logic [NPIN-1:0]  prev_q, prev_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic [3:0] eicra_q, eicra_d;
    logic [1:0] eimsk_q, eimsk_d, eifr_q, eifr_d;
    logic [2:0] pcicr_q, pcicr_d, pcifr_q, pcifr_d;
    logic [7:0] pcmsk0_q, pcmsk0_d, pcmsk2_q, pcmsk2_d;
    logic [6:0] pcmsk1_q, pcmsk1_d;

    logic [NPIN-1:0] cur, tog;
    logic            armed;
    logic [1:0]      int_set, eifr_clr;
    logic [2:0]      pc_set, pcifr_clr;
    logic [7:0]      rd_val;
    logic            unused_pcint15;

    assign cur            = sync_q[SYNC_STAGES-1];
    assign tog            = cur ^ prev_q;
    assign armed          = (arm_q == ARM_W'(ARM_MAX));
    assign unused_pcint15 = tog[15];

    always_comb begin
        sync_d[0] = {int_pins, pcint_pins};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = cur;
        arm_d  = armed ? arm_q : arm_q + ARM_W'(1);
    end

    // Edge detection is held off until the sync chain has flushed its reset zeros.
    always_comb begin
        int_set = '0;
        for (int n = 0; n < 2; n++) begin
            case (eicra_q[2*n +: 2])
                2'b01:   int_set[n] = tog[24+n];
                2'b10:   int_set[n] = tog[24+n] & ~cur[24+n];
                2'b11:   int_set[n] = tog[24+n] & cur[24+n];
                default: int_set[n] = 1'b0;
            endcase
        end
        int_set   = int_set & {2{armed}};
        pc_set[0] = |(tog[7:0]   & pcmsk0_q);
        pc_set[1] = |(tog[14:8]  & pcmsk1_q);
        pc_set[2] = |(tog[23:16] & pcmsk2_q);
        pc_set    = pc_set & {3{armed}};
    end

    always_comb begin
        eifr_clr  = {vec_ack && (vec_num == 6'd2), vec_ack && (vec_num == 6'd1)};
        pcifr_clr = {vec_ack && (vec_num == 6'd5), vec_ack && (vec_num == 6'd4),
                     vec_ack && (vec_num == 6'd3)};
        if (io_we && io_addr == ADDR_EIFR)  eifr_clr  = eifr_clr  | io_wdata[1:0];
        if (io_we && io_addr == ADDR_PCIFR) pcifr_clr = pcifr_clr | io_wdata[2:0];
        eifr_d  = int_set | (eifr_q & ~eifr_clr);
        pcifr_d = pc_set  | (pcifr_q & ~pcifr_clr);

        eicra_d  = (io_we && io_addr == ADDR_EICRA)  ? io_wdata[3:0] : eicra_q;
        eimsk_d  = (io_we && io_addr == ADDR_EIMSK)  ? io_wdata[1:0] : eimsk_q;
        pcicr_d  = (io_we && io_addr == ADDR_PCICR)  ? io_wdata[2:0] : pcicr_q;
        pcmsk0_d = (io_we && io_addr == ADDR_PCMSK0) ? io_wdata      : pcmsk0_q;
        pcmsk1_d = (io_we && io_addr == ADDR_PCMSK1) ? io_wdata[6:0] : pcmsk1_q;
        pcmsk2_d = (io_we && io_addr == ADDR_PCMSK2) ? io_wdata      : pcmsk2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            eicra_q  <= '0;
            eimsk_q  <= '0;
            eifr_q   <= '0;
            pcicr_q  <= '0;
            pcifr_q  <= '0;
            pcmsk0_q <= '0;
            pcmsk1_q <= '0;
            pcmsk2_q <= '0;
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            arm_q    <= arm_d;
            eicra_q  <= eicra_d;
            eimsk_q  <= eimsk_d;
            eifr_q   <= eifr_d;
            pcicr_q  <= pcicr_d;
            pcifr_q  <= pcifr_d;
            pcmsk0_q <= pcmsk0_d;
            pcmsk1_q <= pcmsk1_d;
            pcmsk2_q <= pcmsk2_d;
        end
    end

    // Low-level sense bypasses the flag and follows the synchronized pin directly.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            if (eicra_q[2*n +: 2] == 2'b00) int_req[n] = ~cur[24+n] & eimsk_q[n];
            else                            int_req[n] = eifr_q[n] & eimsk_q[n];
        end
        pcint_req = pcifr_q & pcicr_q;
    end

    assign eimsk_reg  = {6'd0, eimsk_q};
    assign eifr_reg   = {6'd0, eifr_q};
    assign pcicr_reg  = {5'd0, pcicr_q};
    assign pcifr_reg  = {5'd0, pcifr_q};
    assign pcmsk0_reg = pcmsk0_q;
    assign pcmsk1_reg = {1'b0, pcmsk1_q};
    assign pcmsk2_reg = pcmsk2_q;

    always_comb begin
        io_hit = 1'b1;
        rd_val = 8'h00;
        case (io_addr)
            ADDR_PCIFR:  rd_val = pcifr_reg;
            ADDR_EIFR:   rd_val = eifr_reg;
            ADDR_EIMSK:  rd_val = eimsk_reg;
            ADDR_PCICR:  rd_val = pcicr_reg;
            ADDR_EICRA:  rd_val = {4'd0, eicra_q};
            ADDR_PCMSK0: rd_val = pcmsk0_reg;
            ADDR_PCMSK1: rd_val = pcmsk1_reg;
            ADDR_PCMSK2: rd_val = pcmsk2_reg;
            default:     io_hit = 1'b0;
        endcase
        io_rdata = (io_re && io_hit) ? rd_val : 8'h00;
    end
endmodule

// File: tb/tb_axioma_ext_int.sv
// Directed bench for axioma_ext_int: sense modes, PCINT groups, W1C, vector clear, reset/arm.
module tb_axioma_ext_int;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  int_pins;
    logic [23:0] pcint_pins;
    logic [7:0]  io_addr, io_wdata, io_rdata;
    logic        io_we, io_re, io_hit;
    logic        vec_ack;
    logic [5:0]  vec_num;
    logic [1:0]  int_req;
    logic [2:0]  pcint_req;
    logic [7:0]  eimsk_reg, eifr_reg, pcicr_reg, pcifr_reg;
    logic [7:0]  pcmsk0_reg, pcmsk1_reg, pcmsk2_reg;

    int compared   = 0;
    int mismatched = 0;

    axioma_ext_int dut (
        .clk(clk), .reset_n(reset_n), .int_pins(int_pins), .pcint_pins(pcint_pins),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
        .io_rdata(io_rdata), .io_hit(io_hit), .vec_ack(vec_ack), .vec_num(vec_num),
        .int_req(int_req), .pcint_req(pcint_req), .eimsk_reg(eimsk_reg),
        .eifr_reg(eifr_reg), .pcicr_reg(pcicr_reg), .pcifr_reg(pcifr_reg),
        .pcmsk0_reg(pcmsk0_reg), .pcmsk1_reg(pcmsk1_reg), .pcmsk2_reg(pcmsk2_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        io_addr = a; io_wdata = d; io_we = 1'b1;
        tick();
        io_we = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        io_addr = a; io_re = 1'b1;
        #1;
        check(tag, io_rdata, exp);
        io_re = 1'b0;
    endtask

    task automatic vec(input logic [5:0] n);
        vec_ack = 1'b1; vec_num = n;
        tick();
        vec_ack = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; int_pins = '0; pcint_pins = '0;
        io_addr = '0; io_wdata = '0; io_we = 1'b0; io_re = 1'b0;
        vec_ack = 1'b0; vec_num = '0;
        #12;
        check("rst_int_req", int_req, 2'b00);
        check("rst_pcint_req", pcint_req, 3'b000);
        check("rst_eifr", eifr_reg, 8'h00);
        check("rst_pcmsk1", pcmsk1_reg, 8'h00);
        io_addr = 8'h3C; io_re = 1'b1; #1;
        check("rst_rdata", io_rdata, 8'h00);
        check("hit_3c", io_hit, 1'b1);
        io_addr = 8'h3E; #1;
        check("hit_3e", io_hit, 1'b0);
        io_re = 1'b0;
        @(negedge clk) reset_n = 1'b1;
        ticks(4);

        // INT0 rising edge, flag three edges after the pin change
        wr(8'h69, 8'h03);
        wr(8'h3D, 8'h01);
        int_pins[0] = 1'b1;
        ticks(2);
        check("rise_not_yet", eifr_reg, 8'h00);
        tick();
        check("rise_eifr", eifr_reg, 8'h01);
        check("rise_int_req", int_req, 2'b01);
        rd_check("rd_eifr", 8'h3C, 8'h01);
        vec(6'd1);
        check("vec1_eifr", eifr_reg, 8'h00);
        check("vec1_int_req", int_req, 2'b00);

        // any-edge on a falling pin; wrong vector and W1C of 0 leave the flag
        wr(8'h69, 8'h01);
        int_pins[0] = 1'b0;
        ticks(3);
        check("any_fall_eifr", eifr_reg, 8'h01);
        vec(6'd2);
        check("vec2_keeps", eifr_reg, 8'h01);
        wr(8'h3C, 8'h00);
        check("w0_keeps", eifr_reg, 8'h01);
        wr(8'h3C, 8'h01);
        check("w1c_clears", eifr_reg, 8'h00);

        // INT1 low level
        wr(8'h69, 8'h00);
        wr(8'h3D, 8'h02);
        check("lvl_req", int_req, 2'b10);
        ticks(3);
        check("lvl_req_hold", int_req, 2'b10);
        check("lvl_no_flag", eifr_reg, 8'h00);
        int_pins[1] = 1'b1;
        tick();
        check("lvl_release_1", int_req, 2'b10);
        tick();
        check("lvl_release_2", int_req, 2'b00);
        check("lvl_no_flag2", eifr_reg, 8'h00);

        // PCINT group 2
        wr(8'h6D, 8'h10);
        wr(8'h68, 8'h04);
        pcint_pins[20] = 1'b1;
        ticks(3);
        check("pc2_pcifr", pcifr_reg, 8'h04);
        check("pc2_req", pcint_req, 3'b100);
        vec(6'd5);
        check("vec5_pcifr", pcifr_reg, 8'h00);
        check("vec5_req", pcint_req, 3'b000);
        pcint_pins[21] = 1'b1;
        ticks(4);
        check("pc21_masked", pcifr_reg, 8'h00);

        // group 1: bit 7 of PCMSK1 and pin 15 do not exist
        wr(8'h6C, 8'hFF);
        rd_check("rd_pcmsk1", 8'h6C, 8'h7F);
        check("pcmsk1_reg", pcmsk1_reg, 8'h7F);
        pcint_pins[15] = 1'b1;
        ticks(4);
        check("pin15_ignored", pcifr_reg, 8'h00);
        pcint_pins[14] = 1'b1;
        ticks(3);
        check("pc1_pcifr", pcifr_reg, 8'h02);
        check("pc1_req_off", pcint_req, 3'b000);
        wr(8'h3B, 8'h02);
        check("pcifr_w1c", pcifr_reg, 8'h00);

        // W1C in the same edge as a hardware set: set wins
        wr(8'h69, 8'h03);
        int_pins[0] = 1'b1;
        ticks(2);
        io_addr = 8'h3C; io_wdata = 8'h01; io_we = 1'b1;
        tick();
        io_we = 1'b0;
        check("collision_set_wins", eifr_reg, 8'h01);
        wr(8'h3C, 8'h01);
        check("collision_clear", eifr_reg, 8'h00);

        // asynchronous reset with both flags pending
        wr(8'h69, 8'h05);
        wr(8'h3D, 8'h03);
        int_pins = 2'b00;
        ticks(3);
        check("pre_rst_eifr", eifr_reg, 8'h03);
        check("pre_rst_req", int_req, 2'b11);
        reset_n = 1'b0;
        #1;
        check("midrst_eifr", eifr_reg, 8'h00);
        check("midrst_req", int_req, 2'b00);
        check("midrst_eimsk", eimsk_reg, 8'h00);
        int_pins = 2'b11;
        @(negedge clk) reset_n = 1'b1;
        ticks(6);
        check("post_rst_eifr", eifr_reg, 8'h00);

        // arm window: pins high through reset release, sense/masks written immediately
        reset_n = 1'b0; pcint_pins = 24'hFFFFFF; int_pins = 2'b11;
        ticks(2);
        reset_n = 1'b1;
        io_addr = 8'h6B; io_wdata = 8'hFF; io_we = 1'b1;
        tick();
        io_addr = 8'h69; io_wdata = 8'h0F;
        tick();
        io_we = 1'b0;
        ticks(4);
        check("arm_eifr", eifr_reg, 8'h00);
        check("arm_pcifr", pcifr_reg, 8'h00);
        check("arm_pcmsk0", pcmsk0_reg, 8'hFF);
        rd_check("arm_eicra", 8'h69, 8'h0F);
        pcint_pins[0] = 1'b0;
        ticks(3);
        check("armed_pc0", pcifr_reg, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
